// File: rtl/rv32i_enc_pkg.sv
// Shared definitions for the RV32I encoder: mnemonic codes, format classes,
// opcode/funct constants and the immediate range helper.
package rv32i_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
    OP_XOR   = 5'd4,  OP_SLL   = 5'd5,  OP_SRL   = 5'd6,  OP_SRA   = 5'd7,
    OP_SLT   = 5'd8,  OP_SLTU  = 5'd9,  OP_ADDI  = 5'd10, OP_ANDI  = 5'd11,
    OP_ORI   = 5'd12, OP_XORI  = 5'd13, OP_SLTI  = 5'd14, OP_SLTIU = 5'd15,
    OP_SLLI  = 5'd16, OP_SRLI  = 5'd17, OP_SRAI  = 5'd18, OP_LW    = 5'd19,
    OP_SW    = 5'd20, OP_BEQ   = 5'd21, OP_BNE   = 5'd22, OP_BLT   = 5'd23,
    OP_BGE   = 5'd24, OP_BLTU  = 5'd25, OP_BGEU  = 5'd26, OP_JAL   = 5'd27,
    OP_JALR  = 5'd28, OP_LUI   = 5'd29
  } enc_op_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD
  } enc_fmt_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD_C = 32'h0000_0013;

  // True when v is representable as a w-bit two's-complement value.
  function automatic logic fits_s(input logic [31:0] v, input int unsigned w);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (w - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO for encoded words; push is ignored when full, pop when empty.
module enc_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rp];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_wdata;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rv32i_inst_encoder.sv
// Encodes symbolic RV32I instructions into machine words and streams them with
// their word address; out-of-range or unknown instructions become NOP_WORD.
module rv32i_inst_encoder
  import rv32i_enc_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt,
  input  logic              clr_err
);

  enc_fmt_e          w_fmt;
  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [31:0]       w_enc;
  logic              w_ok;
  logic [31:0]       w_word;
  logic [31:0]       w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              r_live;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  always_comb begin
    w_fmt = FMT_BAD;
    w_opc = OPC_I;
    w_f3  = F3_ADD;
    w_f7  = F7_BASE;
    case (in_op)
      OP_ADD:   begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_ADD;  end
      OP_SUB:   begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_ADD;  w_f7 = F7_ALT; end
      OP_AND:   begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_AND;  end
      OP_OR:    begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_OR;   end
      OP_XOR:   begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_XOR;  end
      OP_SLL:   begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_SLL;  end
      OP_SRL:   begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_SR;   end
      OP_SRA:   begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_SR;   w_f7 = F7_ALT; end
      OP_SLT:   begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_SLT;  end
      OP_SLTU:  begin w_fmt = FMT_R;  w_opc = OPC_R; w_f3 = F3_SLTU; end
      OP_ADDI:  begin w_fmt = FMT_I;  w_f3 = F3_ADD;  end
      OP_ANDI:  begin w_fmt = FMT_I;  w_f3 = F3_AND;  end
      OP_ORI:   begin w_fmt = FMT_I;  w_f3 = F3_OR;   end
      OP_XORI:  begin w_fmt = FMT_I;  w_f3 = F3_XOR;  end
      OP_SLTI:  begin w_fmt = FMT_I;  w_f3 = F3_SLT;  end
      OP_SLTIU: begin w_fmt = FMT_I;  w_f3 = F3_SLTU; end
      OP_SLLI:  begin w_fmt = FMT_SH; w_f3 = F3_SLL;  end
      OP_SRLI:  begin w_fmt = FMT_SH; w_f3 = F3_SR;   end
      OP_SRAI:  begin w_fmt = FMT_SH; w_f3 = F3_SR;   w_f7 = F7_ALT; end
      OP_LW:    begin w_fmt = FMT_I;  w_opc = OPC_LOAD;   w_f3 = F3_LW;   end
      OP_JALR:  begin w_fmt = FMT_I;  w_opc = OPC_JALR;   w_f3 = F3_JALR; end
      OP_SW:    begin w_fmt = FMT_S;  w_opc = OPC_STORE;  w_f3 = F3_SW;   end
      OP_BEQ:   begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = F3_BEQ;  end
      OP_BNE:   begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = F3_BNE;  end
      OP_BLT:   begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = F3_BLT;  end
      OP_BGE:   begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = F3_BGE;  end
      OP_BLTU:  begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = F3_BLTU; end
      OP_BGEU:  begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = F3_BGEU; end
      OP_JAL:   begin w_fmt = FMT_J;  w_opc = OPC_JAL; end
      OP_LUI:   begin w_fmt = FMT_U;  w_opc = OPC_LUI; end
      default:  w_fmt = FMT_BAD;
    endcase
  end

  // Branch and jump offsets are byte offsets, so bit 0 must be clear.
  always_comb begin
    w_ok  = 1'b0;
    w_enc = NOP_WORD;
    case (w_fmt)
      FMT_R: begin
        w_ok  = 1'b1;
        w_enc = {w_f7, in_rs2, in_rs1, w_f3, in_rd, w_opc};
      end
      FMT_I: begin
        w_ok  = fits_s(in_imm, 12);
        w_enc = {in_imm[11:0], in_rs1, w_f3, in_rd, w_opc};
      end
      FMT_SH: begin
        w_ok  = (in_imm[31:5] == '0);
        w_enc = {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, w_opc};
      end
      FMT_S: begin
        w_ok  = fits_s(in_imm, 12);
        w_enc = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], w_opc};
      end
      FMT_B: begin
        w_ok  = fits_s(in_imm, 13) & ~in_imm[0];
        w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                 in_imm[4:1], in_imm[11], w_opc};
      end
      FMT_J: begin
        w_ok  = fits_s(in_imm, 21) & ~in_imm[0];
        w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_opc};
      end
      FMT_U: begin
        w_ok  = (in_imm[11:0] == '0);
        w_enc = {in_imm[31:12], in_rd, w_opc};
      end
      default: begin
        w_ok  = 1'b0;
        w_enc = NOP_WORD;
      end
    endcase
    w_word = w_ok ? w_enc : NOP_WORD;
  end

  assign in_ready  = r_live & ~w_full;
  assign out_valid = ~w_empty;
  assign out_inst  = w_empty ? '0 : w_head;
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  enc_fifo2 #(.W(32)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_live    <= 1'b0;
      r_addr    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_live <= 1'b1;
      if (w_pop) r_addr <= r_addr + ADDR_W'(1);
      if (clr_err) begin
        r_err     <= 1'b0;
        r_err_cnt <= 8'd0;
      end else if (w_push && !w_ok) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

endmodule
